// File: rtl/button_debounce.sv
// Push-button/switch conditioner: per-channel 2-flop synchronizer, shared sample-tick
// prescaler, debounce FSM and registered level / press / release / long-press outputs.
module button_debounce #(
  parameter int WIDTH        = 4,
  parameter int TICK_DIV     = 65000,
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS   = 1000
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_release,
  output logic [WIDTH-1:0] btn_long,
  output logic             tick
);

  localparam int DW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS + 32'sd1);
  localparam int HW = $clog2(LONG_TICKS + 32'sd1);

  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 32'sd1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(TICK_DIV - 32'sd2);
  localparam logic [DW-1:0] DIV_ONE  = DW'(32'sd1);
  localparam logic [DW-1:0] DIV_ZERO = {DW{1'b0}};
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 32'sd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'sd1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(32'sd1);
  localparam logic [HW-1:0] HOLD_ZERO = {HW{1'b0}};

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_PEND_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_PEND_LOW  = 2'd3
  } state_e;

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [DW-1:0]    div_cnt_r;
  logic             tick_r;

  state_e           state_r     [WIDTH];
  state_e           state_nxt_s [WIDTH];
  logic [CW-1:0]    cnt_r       [WIDTH];
  logic [CW-1:0]    cnt_nxt_s   [WIDTH];
  logic [HW-1:0]    hold_r      [WIDTH];
  logic [HW-1:0]    hold_nxt_s  [WIDTH];

  logic [WIDTH-1:0] level_nxt_s;
  logic [WIDTH-1:0] press_nxt_s;
  logic [WIDTH-1:0] release_nxt_s;
  logic [WIDTH-1:0] long_nxt_s;

  // Two-flop synchronizer for the asynchronous pins
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
    end
  end

  // Prescaler; tick_r is registered so it is high exactly while the count is TICK_DIV-1
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      div_cnt_r <= DIV_ZERO;
      tick_r    <= 1'b0;
    end else begin
      if (div_cnt_r == DIV_LAST) begin
        div_cnt_r <= DIV_ZERO;
      end else begin
        div_cnt_r <= div_cnt_r + DIV_ONE;
      end
      tick_r <= (div_cnt_r == DIV_PRE);
    end
  end

  assign tick = tick_r;

  // Per-channel state, stable counter and hold counter registers
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_r[i] <= ST_LOW;
        cnt_r[i]   <= CNT_ZERO;
        hold_r[i]  <= HOLD_ZERO;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_r[i] <= state_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
        hold_r[i]  <= hold_nxt_s[i];
      end
    end
  end

  // Next-state logic: a level change always beats a coincident tick
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_nxt_s[i] = state_r[i];
      cnt_nxt_s[i]   = cnt_r[i];
      case (state_r[i])
        ST_LOW: begin
          if (sync2_r[i]) begin
            state_nxt_s[i] = ST_PEND_HIGH;
            cnt_nxt_s[i]   = CNT_ZERO;
          end else begin
            state_nxt_s[i] = ST_LOW;
          end
        end
        ST_PEND_HIGH: begin
          if (!sync2_r[i]) begin
            state_nxt_s[i] = ST_LOW;
          end else if (tick_r) begin
            if (cnt_r[i] == CNT_LAST) begin
              state_nxt_s[i] = ST_HIGH;
            end else begin
              cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
          end else begin
            state_nxt_s[i] = ST_PEND_HIGH;
          end
        end
        ST_HIGH: begin
          if (!sync2_r[i]) begin
            state_nxt_s[i] = ST_PEND_LOW;
            cnt_nxt_s[i]   = CNT_ZERO;
          end else begin
            state_nxt_s[i] = ST_HIGH;
          end
        end
        ST_PEND_LOW: begin
          if (sync2_r[i]) begin
            state_nxt_s[i] = ST_HIGH;
          end else if (tick_r) begin
            if (cnt_r[i] == CNT_LAST) begin
              state_nxt_s[i] = ST_LOW;
            end else begin
              cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
          end else begin
            state_nxt_s[i] = ST_PEND_LOW;
          end
        end
        default: begin
          state_nxt_s[i] = ST_LOW;
          cnt_nxt_s[i]   = CNT_ZERO;
        end
      endcase

      // Hold time survives a release glitch; only a real return to LOW clears it
      if (state_nxt_s[i] == ST_LOW) begin
        hold_nxt_s[i] = HOLD_ZERO;
      end else if (btn_level[i] && tick_r && (hold_r[i] != HOLD_MAX)) begin
        hold_nxt_s[i] = hold_r[i] + HOLD_ONE;
      end else begin
        hold_nxt_s[i] = hold_r[i];
      end
    end
  end

  // Output decode from the current/next state pair
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      level_nxt_s[i]   = (state_nxt_s[i] == ST_HIGH) || (state_nxt_s[i] == ST_PEND_LOW);
      press_nxt_s[i]   = (state_r[i] == ST_PEND_HIGH) && (state_nxt_s[i] == ST_HIGH);
      release_nxt_s[i] = (state_r[i] == ST_PEND_LOW) && (state_nxt_s[i] == ST_LOW);
      long_nxt_s[i]    = (hold_nxt_s[i] == HOLD_MAX) && (hold_r[i] != HOLD_MAX);
    end
  end

  // Registered outputs, updated on the same edge as the state
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      btn_level   <= {WIDTH{1'b0}};
      btn_press   <= {WIDTH{1'b0}};
      btn_release <= {WIDTH{1'b0}};
      btn_long    <= {WIDTH{1'b0}};
    end else begin
      btn_level   <= level_nxt_s;
      btn_press   <= press_nxt_s;
      btn_release <= release_nxt_s;
      btn_long    <= long_nxt_s;
    end
  end

endmodule
